ddr_burst_reader: RTL



---
 rtl/ddr_burst_reader_if.sv | 34 +++
 rtl/ddr_burst_reader.sv | 102 ++++++++++
 2 files changed

// File: rtl/ddr_burst_reader_if.sv
// ddr_burst_reader_if: job control, DDR burst channel and output stream of the burst reader
interface ddr_burst_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_SIZE-1:0]  cfg_base_addr;
  logic [LEN_WIDTH-1:0]  cfg_total_len;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  burst_read_req;
  logic [ADDR_SIZE-1:0]  burst_read_addr;
  logic [LEN_WIDTH-1:0]  burst_read_len;
  logic [DATA_WIDTH-1:0] burst_read_data;
  logic                  burst_read_valid;
  logic                  burst_read_finish;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  modport master (
    input  start, cfg_base_addr, cfg_total_len,
    input  burst_read_data, burst_read_valid, burst_read_finish, out_ready,
    output busy, done, err, burst_read_req, burst_read_addr, burst_read_len,
    output out_data, out_valid
  );
  modport slave (
    output start, cfg_base_addr, cfg_total_len,
    output burst_read_data, burst_read_valid, burst_read_finish, out_ready,
    input  busy, done, err, burst_read_req, burst_read_addr, burst_read_len,
    input  out_data, out_valid
  );
endinterface

// File: rtl/ddr_burst_reader.sv
// ddr_burst_reader: splits a read job into DDR bursts and buffers returned beats in a FWFT FIFO
module ddr_burst_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 64,
  parameter int FIFO_DEPTH = 128
) (
  input logic                user_clk,
  input logic                user_rst,
  ddr_burst_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {IDLE, CALC, WAIT_SPACE, RECV, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_SIZE-1:0]  cur_addr_q, cur_addr_d, addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d, cur_len_q, cur_len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d, len_q, len_d, free;
  logic                  err_q, err_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  accept, fire, beat, fin, last, full, empty, push, pop, mismatch;
  always_comb begin
    free     = LEN_WIDTH'(FIFO_DEPTH) - LEN_WIDTH'(cnt_q);
    full     = cnt_q == CW'(FIFO_DEPTH);
    empty    = cnt_q == '0;
    accept   = state_q == IDLE && bus.start;
    fire     = state_q == WAIT_SPACE && free >= cur_len_q;
    beat     = state_q == RECV && bus.burst_read_valid;
    fin      = state_q == RECV && bus.burst_read_finish;
    last     = remaining_q == cur_len_q;
    push     = beat && !full;
    pop      = bus.out_ready && !empty;
    mismatch = fin && (beat_cnt_q + LEN_WIDTH'(beat)) != cur_len_q;
  end
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.start) state_d = bus.cfg_total_len == '0 ? DONE : CALC;
      CALC:       state_d = WAIT_SPACE;
      WAIT_SPACE: if (fire) state_d = RECV;
      RECV:       if (fin) state_d = last ? DONE : CALC;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.busy            = state_q != IDLE;
    bus.done            = state_q == DONE;
    bus.err             = err_q;
    bus.burst_read_req  = fire;
    bus.burst_read_addr = fire ? cur_addr_q : addr_q;
    bus.burst_read_len  = fire ? cur_len_q : len_q;
    bus.out_valid       = !empty;
    bus.out_data        = empty ? '0 : mem_q[rd_q];
  end
  // the job cursor advances only at finish, so a short burst still moves on by its requested length
  always_comb begin
    cur_addr_d  = accept ? {bus.cfg_base_addr[ADDR_SIZE-1:3], 3'b000}
                : fin ? cur_addr_q + ADDR_SIZE'({cur_len_q, 3'b000}) : cur_addr_q;
    remaining_d = accept ? bus.cfg_total_len : fin ? remaining_q - cur_len_q : remaining_q;
    cur_len_d   = state_q != CALC ? cur_len_q
                : remaining_q < LEN_WIDTH'(MAX_BURST) ? remaining_q : LEN_WIDTH'(MAX_BURST);
    beat_cnt_d  = state_q == CALC ? '0 : beat ? beat_cnt_q + 1'b1 : beat_cnt_q;
    err_d       = accept ? 1'b0 : err_q | mismatch | (beat && full);
    addr_d      = fire ? cur_addr_q : addr_q;
    len_d       = fire ? cur_len_q : len_q;
    wr_d        = wr_q + PW'(push);
    rd_d        = rd_q + PW'(pop);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      cur_len_q   <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      cur_len_q   <= cur_len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  always_ff @(posedge user_clk)
    if (push) mem_q[wr_q] <= bus.burst_read_data;
endmodule
